// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle ARM core bus: word RAM with programmable wait states,
// one-cycle Ready pulse and saturating write counter. Build macro MEM_ALIGN_CHECK_EN rejects Adr[1:0] != 0.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Adr,
  input  logic [31:0]      WriteData,
  input  logic             MemWrite,
  input  logic             MemRead,
  output logic [31:0]      ReadData,
  output logic             Ready,
  output logic             AddrError,
  output logic [CNT_W-1:0] WriteCount,
  output logic             Busy
);

  localparam int               AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0]      DEPTH_IDX = 30'(DEPTH_WORDS);
  localparam logic [3:0]       WAIT_LD   = 4'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             write_q, write_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             aerr_q, aerr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] wcount_q, wcount_d;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic range_err_s;
  logic misalign_s;
  logic commit_s;

  assign range_err_s = (Adr[31:2] >= DEPTH_IDX);
  assign commit_s    = (state_q == ST_RESP) && write_q && !err_q;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = (Adr[1:0] != 2'b00);
`else
  logic unused_adr_s;
  assign misalign_s   = 1'b0;
  assign unused_adr_s = ^Adr[1:0];
`endif

  // Next-state, request latching and registered-output precomputation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    err_d    = err_q;
    wcount_d = wcount_q;
    case (state_q)
      ST_IDLE: begin
        if (MemWrite || MemRead) begin
          idx_d   = Adr[AW+1:2];
          wdata_d = WriteData;
          write_d = MemWrite;
          err_d   = range_err_s || misalign_s;
          cnt_d   = WAIT_LD;
          if (WAIT_LD == 4'd0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (commit_s && (wcount_q != CNT_MAX)) begin
          wcount_d = wcount_q + CNT_W'(1);
        end else begin
          wcount_d = wcount_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    ready_d = (state_d == ST_RESP);
    aerr_d  = ready_d && err_d;
    busy_d  = (state_d != ST_IDLE);
    if (ready_d && !write_d && !err_d) begin
      rdata_d = mem_q[idx_d];
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // Control state, latched request and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= {AW{1'b0}};
      wdata_q  <= 32'h0000_0000;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      aerr_q   <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      busy_q   <= 1'b0;
      wcount_q <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      aerr_q   <= aerr_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      wcount_q <= wcount_d;
    end
  end

  // RAM write port; contents survive reset but a write in a reset cycle is discarded
  always_ff @(posedge clk) begin
    if (reset && commit_s) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign ReadData   = rdata_q;
  assign Ready      = ready_q;
  assign AddrError  = aerr_q;
  assign WriteCount = wcount_q;
  assign Busy       = busy_q;

endmodule
